glitch_sequencer: RTL

- Trigger-driven pulse scheduler behind the glitcher AXI4-Lite register file.
- Software writes delay, width, gap and repeat registers, then arms the block.
- An external trigger edge starts a precisely timed train of glitch pulses on glitch_out.
- The register block feeds cfg_* and arm/abort and reads back the status outputs.

---
 rtl/glitch_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/glitch_sequencer.sv
// Trigger-driven glitch pulse scheduler: after arm, a synchronized trigger edge
// launches delay, then `repeat` pulses of `width` cycles separated by `gap` cycles.
module glitch_sequencer #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned REP_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [REP_W-1:0] cfg_repeat,
  input  logic             cfg_trig_pol,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig_in,
  output logic             glitch_out,
  output logic             armed,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] pulse_cnt,
  output logic             err_cfg
);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StDelay,
    StPulse,
    StGap,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [REP_W-1:0]       pcnt_q, pcnt_d;
  logic [CNT_W-1:0]       delay_q, delay_d;
  logic [CNT_W-1:0]       width_q, width_d;
  logic [CNT_W-1:0]       gap_q, gap_d;
  logic [REP_W-1:0]       rep_q, rep_d;
  logic                   pol_q, pol_d;
  logic                   glitch_q, glitch_d;
  logic                   err_q, err_d;

  logic             trig_sync;
  logic             edge_det;
  logic [REP_W-1:0] pcnt_inc;

  assign trig_sync = sync_q[SYNC_STAGES-1];
  assign edge_det  = (trig_sync != hist_q) && (trig_sync == pol_q);
  assign pcnt_inc  = (pcnt_q == {REP_W{1'b1}}) ? pcnt_q : pcnt_q + REP_W'(1);

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], trig_in};
    hist_d   = trig_sync;
    state_d  = state_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    delay_d  = delay_q;
    width_d  = width_q;
    gap_d    = gap_q;
    rep_d    = rep_q;
    pol_d    = pol_q;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arm && !abort) begin
          if (cfg_width != '0) begin
            state_d = StArmed;
            delay_d = cfg_delay;
            width_d = cfg_width;
            // Zero gap/repeat are folded into their minimum legal value at latch time.
            gap_d   = (cfg_gap == '0) ? CNT_W'(1) : cfg_gap;
            rep_d   = (cfg_repeat == '0) ? REP_W'(1) : cfg_repeat;
            pol_d   = cfg_trig_pol;
            pcnt_d  = '0;
            // History reloads from the synchronizer so stale edges cannot fire on arm.
            hist_d  = trig_sync;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StArmed: begin
        if (edge_det) begin
          if (delay_q != '0) begin
            state_d = StDelay;
            cnt_d   = delay_q - CNT_W'(1);
          end else begin
            state_d = StPulse;
            cnt_d   = width_q - CNT_W'(1);
          end
        end
      end
      StDelay: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = width_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          pcnt_d = pcnt_inc;
          if (pcnt_inc == rep_q) begin
            state_d = StDone;
          end else begin
            state_d = StGap;
            cnt_d   = gap_q - CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = width_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything and leaves the pulse count untouched.
    if (abort) begin
      state_d = StIdle;
      pcnt_d  = pcnt_q;
    end

    glitch_d = (state_d == StPulse);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= StIdle;
      sync_q   <= '0;
      hist_q   <= 1'b0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      delay_q  <= '0;
      width_q  <= '0;
      gap_q    <= '0;
      rep_q    <= '0;
      pol_q    <= 1'b0;
      glitch_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      delay_q  <= delay_d;
      width_q  <= width_d;
      gap_q    <= gap_d;
      rep_q    <= rep_d;
      pol_q    <= pol_d;
      glitch_q <= glitch_d;
      err_q    <= err_d;
    end
  end

  assign glitch_out = glitch_q;
  assign armed      = (state_q == StArmed);
  assign busy       = (state_q == StDelay) || (state_q == StPulse) || (state_q == StGap);
  assign done       = (state_q == StDone);
  assign pulse_cnt  = pcnt_q;
  assign err_cfg    = err_q;

endmodule
